// File: rtl/crc_frame_checker_if.sv
// Link-side bundle for the receive CRC checker: word stream in, frame verdict out.
interface crc_frame_checker_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH:0]   polynom_i;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             frame_done;
  logic             frame_ok;
  logic             err_short;
  logic [WIDTH-1:0] crc_rem;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output polynom_i, in_data, in_valid, in_last,
    input  in_ready, frame_done, frame_ok, err_short, crc_rem, word_cnt
  );

  modport slave (
    input  polynom_i, in_data, in_valid, in_last,
    output in_ready, frame_done, frame_ok, err_short, crc_rem, word_cnt
  );
endinterface

// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: bit-serial MSB-first division over every word of a
// frame (appended CRC included); a good frame leaves a zero remainder.
module crc_frame_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_frame_checker_if.slave   bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_crc, r_data, r_poly;
  logic             r_last;
  logic [BW-1:0]    r_bitcnt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_ok, r_err_short;
  logic [WIDTH-1:0] r_crc_rem;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_in_ready, w_frame_done, w_accept, w_fb, w_short;
  logic [WIDTH-1:0] w_crc_nxt;
  logic             w_unused;

  // The x^WIDTH term is implicit in the shift.
  assign w_unused = bus.polynom_i[WIDTH];

  assign w_fb      = r_crc[WIDTH-1] ^ r_data[r_bitcnt];
  assign w_crc_nxt = {r_crc[WIDTH-2:0], 1'b0} ^ (w_fb ? r_poly : '0);
  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_short   = (r_cnt < CNT_W'(2));

  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = rst;
        if (bus.in_valid && rst) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (r_bitcnt == '0) w_state_nxt = r_last ? DONE : WAIT;
      end
      WAIT: begin
        w_in_ready = rst;
        if (bus.in_valid && rst) w_state_nxt = SHIFT;
      end
      DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_crc       <= '0;
      r_data      <= '0;
      r_poly      <= '0;
      r_last      <= 1'b0;
      r_bitcnt    <= '0;
      r_cnt       <= '0;
      r_frame_ok  <= 1'b0;
      r_err_short <= 1'b0;
      r_crc_rem   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data   <= bus.in_data;
        r_last   <= bus.in_last;
        r_bitcnt <= BW'(WIDTH - 1);
        if (r_state == IDLE) begin
          r_poly <= bus.polynom_i[WIDTH-1:0];
          r_cnt  <= CNT_W'(1);
          r_crc  <= '0;
        end else if (r_cnt != '1) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (r_state == SHIFT) begin
        r_crc <= w_crc_nxt;
        if (r_bitcnt != '0) begin
          r_bitcnt <= r_bitcnt - BW'(1);
        end else if (r_last) begin
          // Results land on the edge entering DONE so they are valid with frame_done.
          r_crc_rem   <= w_crc_nxt;
          r_word_cnt  <= r_cnt;
          r_err_short <= w_short;
          r_frame_ok  <= (w_crc_nxt == '0) && !w_short;
        end
      end
      if (r_state == DONE) r_crc <= '0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.frame_done = w_frame_done;
  assign bus.frame_ok   = r_frame_ok;
  assign bus.err_short  = r_err_short;
  assign bus.crc_rem    = r_crc_rem;
  assign bus.word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: CRC-32 frames, handshake timing, reset abort, poly latch.
module tb_crc_frame_checker;
  localparam int W  = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  crc_frame_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  crc_frame_checker #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int last_acc = 0;
  int prev_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && bus.in_valid && bus.in_ready) begin
      last_acc <= cyc + 1;
      prev_acc <= last_acc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 64'(n >= 200), 64'd0);
    if (n < 200) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int c);
    int n;
    c = -1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (bus.frame_done) begin
        c = cyc;
        break;
      end
      n++;
    end
    chk("done_timeout", 64'(c < 0), 64'd0);
  endtask

  task automatic chk_result(input string tag, input logic ok, input logic es,
                            input logic [31:0] rem, input logic [15:0] cnt, input logic do_rem);
    int dc;
    wait_done(dc);
    chk({tag, "_lat"}, 64'(dc - last_acc), 64'd32);
    chk({tag, "_ok"}, 64'(bus.frame_ok), 64'(ok));
    chk({tag, "_short"}, 64'(bus.err_short), 64'(es));
    chk({tag, "_cnt"}, 64'(bus.word_cnt), 64'(cnt));
    if (do_rem) chk({tag, "_rem"}, 64'(bus.crc_rem), 64'(rem));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_hold"}, 64'(bus.frame_ok), 64'(ok));
  endtask

  initial begin
    int dn;
    bus.polynom_i = 33'h1_04C1_1DB7;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_done", 64'(bus.frame_done), 64'd0);
    chk("rst_ok", 64'(bus.frame_ok), 64'd0);
    chk("rst_short", 64'(bus.err_short), 64'd0);
    chk("rst_rem", 64'(bus.crc_rem), 64'd0);
    chk("rst_cnt", 64'(bus.word_cnt), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(bus.in_ready), 64'd1);

    // good frame
    send(32'h0000_0001, 1'b0);
    send(32'h04C1_1DB7, 1'b1);
    bus.in_valid = 1'b0;
    chk_result("good", 1'b1, 1'b0, 32'h0, 16'd2, 1'b1);

    // corrupted CRC word
    send(32'h0000_0001, 1'b0);
    send(32'h04C1_1DB6, 1'b1);
    bus.in_valid = 1'b0;
    chk_result("bad", 1'b0, 1'b0, 32'h04C1_1DB7, 16'd2, 1'b1);

    // single-word frame
    send(32'h1234_5678, 1'b1);
    bus.in_valid = 1'b0;
    chk_result("short", 1'b0, 1'b1, 32'h0, 16'd1, 1'b0);

    // back-to-back with in_valid held high
    send(32'h0, 1'b0);
    chk("b2b_busy", 64'(bus.in_ready), 64'd0);
    send(32'h0, 1'b0);
    chk("b2b_gap1", 64'(last_acc - prev_acc), 64'd33);
    send(32'h0, 1'b1);
    chk("b2b_gap2", 64'(last_acc - prev_acc), 64'd33);
    bus.in_valid = 1'b0;
    chk_result("b2b", 1'b1, 1'b0, 32'h0, 16'd3, 1'b1);

    // reset during the second word's shift
    send(32'h0000_0001, 1'b0);
    send(32'h04C1_1DB7, 1'b1);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dn = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.frame_done) dn++;
    end
    chk("abort_nodone", 64'(dn), 64'd0);
    chk("abort_cnt", 64'(bus.word_cnt), 64'd0);
    chk("abort_ok", 64'(bus.frame_ok), 64'd0);
    send(32'h0000_0001, 1'b0);
    send(32'h04C1_1DB7, 1'b1);
    bus.in_valid = 1'b0;
    chk_result("post_rst", 1'b1, 1'b0, 32'h0, 16'd2, 1'b1);

    // polynomial changes right after the first word is accepted
    send(32'h0000_0001, 1'b0);
    bus.polynom_i = 33'h1_0000_0007;
    send(32'h04C1_1DB7, 1'b1);
    bus.in_valid = 1'b0;
    chk_result("latch", 1'b1, 1'b0, 32'h0, 16'd2, 1'b1);
    bus.polynom_i = 33'h1_04C1_1DB7;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/crc_frame_checker.md
# crc_frame_checker

Receive-side CRC checker for the CRC block family. It accepts a framed word stream whose last word is the CRC appended by the CRC generator. It runs bit-serial polynomial division over every word, including the appended CRC, and flags the frame good when the final remainder is zero. It sits between the link input and frame consumers, and is the receive counterpart of the CRC generator.

## Interface
Parameters:
- WIDTH, 32, data word and CRC width in bits
- CNT_W, 16, width of the frame word counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- polynom_i  in  WIDTH+1  generator polynomial; bit WIDTH is the implicit x^WIDTH term and is ignored
- in_data  in  WIDTH  input word
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final word of the frame (the CRC word)
- in_ready  out  1  checker can accept a word
- frame_done  out  1  one-cycle pulse: frame result valid
- frame_ok  out  1  frame passed the check
- err_short  out  1  frame had fewer than 2 words
- crc_rem  out  WIDTH  final remainder of the last frame
- word_cnt  out  CNT_W  words accepted in the last frame, including the CRC word; saturating

## Operation
- Transfer occurs when in_valid && in_ready. The word, in_last and (first word only) polynom_i[WIDTH-1:0] are captured.
- The polynomial is latched on the first word of each frame. Changes to polynom_i mid-frame are ignored.
- CRC register R is cleared to 0 at frame start. There is no reflection and no final XOR.
- Per bit, MSB first: fb = R[WIDTH-1] ^ bit; R <= {R[WIDTH-2:0],1'b0} ^ (fb ? poly : 0).
- After the message words, R = M·x^WIDTH mod P. The appended CRC word drives R to 0 iff it is correct.
- FSM states:
  - IDLE: in_ready=1, R=0. Accept → SHIFT, word_cnt internal counter=1.
  - SHIFT: in_ready=0. Bit counter runs WIDTH-1 down to 0, one bit per cycle. At bit 0: if the captured last flag is set → DONE, else → WAIT.
  - WAIT: in_ready=1, mid-frame. Accept → SHIFT, counter+1 (saturates at all-ones).
  - DONE: in_ready=0, frame_done=1 for exactly this cycle. Outputs are updated. Next state is IDLE.
- Result on DONE:
  - crc_rem = R
  - word_cnt = count
  - err_short = (count < 2)
  - frame_ok = (R == 0) && !err_short
- frame_ok, err_short, crc_rem and word_cnt hold until the next DONE.
- in_valid while in_ready=0 is not a transfer. The source holds data; the checker never drops or double-counts a word.

## Timing
- Reset (rst low at a clk edge): state=IDLE, R=0, bit counter=0, frame_done=0, frame_ok=0, err_short=0, crc_rem=0, word_cnt=0. in_ready is forced 0 while rst is low.
- Reset mid-frame aborts the frame with no frame_done. The first word accepted after reset starts a new frame.
- Word accepted at edge k: R is updated on edges k+1..k+WIDTH. SHIFT lasts exactly WIDTH cycles.
- in_ready reasserts in the cycle after edge k+WIDTH, in WAIT or IDLE.
- For a last word accepted at edge k: DONE state, with frame_done high and result outputs valid, occupies the cycle after edge k+WIDTH.
- IDLE follows one cycle later, so a new frame can be accepted at edge k+WIDTH+2.
- Maximum throughput: one word per WIDTH+1 cycles within a frame.
- A single-word frame (first word has in_last=1) still shifts the full word, then reports err_short=1, frame_ok=0.

## Test plan
All cases use WIDTH=32 and polynom_i=33'h1_04C1_1DB7 unless stated.
- Frame {32'h0000_0001, 32'h04C1_1DB7(last)} → frame_done one pulse, frame_ok=1, crc_rem=0, word_cnt=2, err_short=0.
- Frame {32'h0000_0001, 32'h04C1_1DB6(last)} → frame_ok=0, crc_rem=32'h04C1_1DB7, word_cnt=2.
- Frame {32'h1234_5678(last)} → frame_ok=0, err_short=1, word_cnt=1.
- Handshake timing: in_valid held high across a 3-word zero frame {0,0,0(last)}:
  - in_ready is high for one cycle, then low for 32 cycles, per word.
  - frame_done occurs exactly 32 cycles after the last acceptance edge; frame_ok=1, word_cnt=3.
- Reset robustness: rst low for one cycle during SHIFT of word 2, then send frame {32'h0000_0001, 32'h04C1_1DB7(last)} → no frame_done from the aborted frame; the new frame gives frame_ok=1, word_cnt=2.
- Polynomial latch: change polynom_i to 33'h1_0000_0007 after the first word of the case-1 frame → result still frame_ok=1.
